// File: rtl/alu_pipe.sv
// alu_pipe: two-stage N-bit ALU with valid/ready handshakes on both sides.
// Define ALU_PIPE_SAT_EN to saturate ADD/SUB results on signed overflow.
module alu_pipe #(
  parameter int N   = 32,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           c_in,
  input  logic [OPW-1:0] ALUOp,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   overall_out,
  output logic           c_out,
  output logic [3:0]     flags
);

  localparam logic [OPW-1:0] OP_MOV  = 3'b000;
  localparam logic [OPW-1:0] OP_NOT  = 3'b001;
  localparam logic [OPW-1:0] OP_ADD  = 3'b010;
  localparam logic [OPW-1:0] OP_SUB  = 3'b011;
  localparam logic [OPW-1:0] OP_OR   = 3'b100;
  localparam logic [OPW-1:0] OP_AND  = 3'b101;
  localparam logic [OPW-1:0] OP_SLT  = 3'b110;
  localparam logic [OPW-1:0] OP_SLTU = 3'b111;

  logic           s1_valid_q, s1_valid_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           cin_q, cin_d;
  logic [OPW-1:0] op_q, op_d;

  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   res_q, res_d;
  logic           cout_q, cout_d;
  logic [3:0]     flags_q, flags_d;

  logic           s1_load, s2_load;
  logic           sub, arith, ovf, cout, lt_s, lt_u;
  logic [N-1:0]   bx, res;
  logic [N:0]     sum;

  assign in_ready = !s1_valid_q || !out_valid_q || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);

  // SUB reuses the adder as a + ~b + 1
  always_comb begin
    sub   = (op_q == OP_SUB);
    arith = (op_q == OP_ADD) || sub;
    bx    = sub ? ~b_q : b_q;
    sum   = {1'b0, a_q} + {1'b0, bx}
          + {{N{1'b0}}, (sub ? 1'b1 : cin_q)};
    ovf   = arith && (a_q[N-1] == bx[N-1])
                  && (sum[N-1] != a_q[N-1]);
    cout  = arith && sum[N];
    lt_s  = $signed(a_q) < $signed(b_q);
    lt_u  = a_q < b_q;
    res   = '0;
    case (op_q)
      OP_MOV:  res = a_q;
      OP_NOT:  res = ~a_q;
      OP_ADD:  res = sum[N-1:0];
      OP_SUB:  res = sum[N-1:0];
      OP_OR:   res = a_q | b_q;
      OP_AND:  res = a_q & b_q;
      OP_SLT:  res = {{(N-1){1'b0}}, lt_s};
      OP_SLTU: res = {{(N-1){1'b0}}, lt_u};
      default: res = '0;
    endcase
`ifdef ALU_PIPE_SAT_EN
    if (ovf) begin
      res = a_q[N-1] ? {1'b1, {(N-1){1'b0}}}
                     : {1'b0, {(N-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    cout_d      = cout_q;
    flags_d     = flags_q;
    if (s2_load) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b1;
      res_d       = res;
      cout_d      = cout;
      flags_d     = {res[N-1], (res == '0), ovf, cout};
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (s1_load) begin
      s1_valid_d = 1'b1;
      a_d        = a;
      b_d        = b;
      cin_d      = c_in;
      op_d       = ALUOp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      cout_q      <= 1'b0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      cout_q      <= cout_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign overall_out = res_q;
  assign c_out       = cout_q;
  assign flags       = flags_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe, directed vectors,
// back-pressure, streaming and mid-flight reset.
module tb_alu_pipe;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         c_in = 1'b0;
  logic [2:0]   ALUOp = 3'b000;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] overall_out;
  logic         c_out;
  logic [3:0]   flags;

  always #5 clk = ~clk;

  alu_pipe #(.N(N), .OPW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .ALUOp(ALUOp),
    .out_valid(out_valid), .out_ready(out_ready),
    .overall_out(overall_out), .c_out(c_out), .flags(flags)
  );

  typedef struct packed {
    logic [N-1:0] r;
    logic         c;
    logic [3:0]   f;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   stream_on = 0;
  int   sv = 0;
  int   first = -1;
  int   last = -1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Independent reference: wide signed/unsigned integer arithmetic
  function automatic exp_t model(input logic [2:0] op,
                                 input logic [N-1:0] x,
                                 input logic [N-1:0] y,
                                 input logic ci);
    exp_t   e;
    longint sx, sy, sr;
    logic [N:0] w;
    logic   ovf;
    sx  = $signed(x);
    sy  = $signed(y);
    sr  = 0;
    ovf = 1'b0;
    e   = '0;
    case (op)
      3'd0: e.r = x;
      3'd1: e.r = ~x;
      3'd2: begin
        w   = x + y + ci;
        e.r = w[N-1:0];
        e.c = w[N];
        sr  = sx + sy + longint'(ci);
      end
      3'd3: begin
        e.r = x - y;
        e.c = (x >= y);
        sr  = sx - sy;
      end
      3'd4: e.r = x | y;
      3'd5: e.r = x & y;
      3'd6: e.r = (sx < sy) ? 1 : 0;
      default: e.r = (x < y) ? 1 : 0;
    endcase
    if (op == 3'd2 || op == 3'd3)
      ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef ALU_PIPE_SAT_EN
    if (ovf) e.r = (sr > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
    e.f = {e.r[N-1], (e.r == 0), ovf, e.c};
    return e;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out", out_valid, 1'b0);
        end else begin
          chk("res", overall_out, sb[0].r);
          chk("cout", c_out, sb[0].c);
          chk("flags", flags, sb[0].f);
          if (out_ready) void'(sb.pop_front());
        end
        if (stream_on) begin
          sv++;
          if (first < 0) first = cyc;
          last = cyc;
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(ALUOp, a, b, c_in));
    end
  end

  task automatic send(input logic [2:0] op, input logic [N-1:0] x,
                      input logic [N-1:0] y, input logic ci);
    ALUOp = op; a = x; b = y; c_in = ci; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("send_rdy", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic one(input string tag, input logic [2:0] op,
                     input logic [N-1:0] x, input logic [N-1:0] y,
                     input logic ci, input logic [N-1:0] er,
                     input logic ec, input logic [3:0] ef);
    send(op, x, y, ci);
    chk({tag, "_lat0"}, out_valid, 1'b0);
    @(posedge clk); #1;
    chk({tag, "_v"}, out_valid, 1'b1);
    chk({tag, "_r"}, overall_out, er);
    chk({tag, "_c"}, c_out, ec);
    chk({tag, "_f"}, flags, ef);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ne;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_out", overall_out, 32'h0);
    chk("rst_c", c_out, 1'b0);
    chk("rst_f", flags, 4'h0);
    chk("rst_rdy", in_ready, 1'b1);
    @(posedge clk); #1;

    one("add", 3'b010, 32'hFFFFFFFF, 32'h0000000A, 1'b0,
        32'h00000009, 1'b1, 4'b0001);
    one("sub0", 3'b011, 32'hFA230B01, 32'hFA230B01, 1'b0,
        32'h0, 1'b1, 4'b0101);
    one("sub1", 3'b011, 32'h00AAF2FD, 32'hFA230B01, 1'b1,
        32'h0687E7FC, 1'b0, 4'b0000);
    one("slt", 3'b110, 32'hFFFFABCD, 32'h0000ADBC, 1'b0,
        32'h1, 1'b0, 4'b0000);
    one("sltu", 3'b111, 32'hFFFFABCD, 32'h0000ADBC, 1'b0,
        32'h0, 1'b0, 4'b0100);
    one("addc", 3'b010, 32'h1, 32'h2, 1'b1, 32'h4, 1'b0, 4'b0000);
    one("not", 3'b001, 32'h0, 32'h5, 1'b1,
        32'hFFFFFFFF, 1'b0, 4'b1000);
    one("and", 3'b101, 32'hF0F0FFFF, 32'h0F0F0F0F, 1'b0,
        32'h00000F0F, 1'b0, 4'b0000);
`ifdef ALU_PIPE_SAT_EN
    one("povf", 3'b010, 32'h7FFFFFFF, 32'h1, 1'b0,
        32'h7FFFFFFF, 1'b0, 4'b0010);
    one("novf", 3'b011, 32'h80000000, 32'h1, 1'b0,
        32'h80000000, 1'b1, 4'b1011);
`else
    one("povf", 3'b010, 32'h7FFFFFFF, 32'h1, 1'b0,
        32'h80000000, 1'b0, 4'b1010);
    one("novf", 3'b011, 32'h80000000, 32'h1, 1'b0,
        32'h7FFFFFFF, 1'b1, 4'b0011);
`endif

    // back-pressure: two beats fill the pipe, third waits
    out_ready = 1'b0;
    ALUOp = 3'b000; a = 32'h1; b = '0; c_in = 1'b0;
    in_valid = 1'b1;
    ne = 0;
    for (int i = 0; i < 20 && ne < 2; i++) begin
      @(negedge clk);
      if (in_ready) ne++;
      @(posedge clk); #1;
      a = ne + 1;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rdy", in_ready, 1'b0);
      chk("bp_ov", out_valid, 1'b1);
      chk("bp_hold", overall_out, 32'h1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_o1", overall_out, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_v2", out_valid, 1'b1);
    chk("bp_o2", overall_out, 32'h2);
    @(negedge clk);
    chk("bp_v3", out_valid, 1'b1);
    chk("bp_o3", overall_out, 32'h3);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    // streaming at one beat per cycle
    stream_on = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ALUOp = 3'($urandom_range(0, 7));
      a = (i % 5 == 0) ? 32'h7FFFFFFF : $urandom;
      b = (i % 7 == 0) ? 32'h80000000 : $urandom;
      c_in = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    stream_on = 1'b0;
    chk("stream_n", sv, 16);
    chk("stream_span", last - first + 1, 16);

    // reset while two beats are in flight
    out_ready = 1'b0;
    ALUOp = 3'b000; a = 32'h55; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 32'h66;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_ov", out_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("mrst_ov", out_valid, 1'b0);
    chk("mrst_out", overall_out, 32'h0);
    chk("mrst_f", flags, 4'h0);
    chk("mrst_rdy", in_ready, 1'b1);
    ne = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) ne++;
    end
    chk("mrst_noemit", ne, 0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
